sync_pulse_gen: RTL and testbench
=================================

Name: sync_pulse_gen

Overview:
- Generates single-cycle `sync` pulses in the clka domain. These feed the downstream pulse-expansion/CDC stage that raises the clkb-domain output window.
- Supports programmable periodic bursts (finite or continuous) and one-shot manual triggers.
- Enforces a minimum spacing between pulses so every toggle of the downstream expander is held long enough for the slower clkb domain to sample it.

Parameters:
- PERIOD_W, 8, width of the `period` input.
- CNT_W, 8, width of `burst_len` and `pulse_cnt`.
- MIN_GAP, 6, minimum number of clka cycles from one `sync` rise to the next. Must be at least 3 × (clka/clkb frequency ratio).

Ports:
- clka  in  1  clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start a periodic burst; honoured in IDLE only.
- stop  in  1  abort a running burst.
- manual_trig  in  1  request one pulse; honoured in IDLE only.
- period  in  PERIOD_W  pulse period in clka cycles; sampled when start is accepted.
- burst_len  in  CNT_W  number of pulses in the burst; 0 means continuous. Sampled when start is accepted.
- sync  out  1  registered single-cycle pulse to the downstream CDC stage.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a finite burst completes.
- trig_drop  out  1  one-cycle pulse when a manual_trig is rejected.
- pulse_cnt  out  CNT_W  pulses emitted in the current or last burst.

Behaviour:
- Reset values: sync=0, busy=0, done=0, trig_drop=0, pulse_cnt=0, state=IDLE, gap counter=MIN_GAP (saturated, so a pulse is allowed immediately after reset).
- All outputs are registered.
- Gap counter:
  - Clears to 0 on the cycle `sync` is high.
  - Otherwise increments, saturating at MIN_GAP.
  - "Gap ok" means the counter equals MIN_GAP.
- eff_period = max(period, MIN_GAP). This also covers period=0. It is latched on start into a period register.
- IDLE state:
  - If start=1, stop=0 and gap ok: go to RUN. busy=1 and sync=1 on the next cycle, pulse_cnt=1, and the down-counter loads eff_period-1.
  - start with gap not ok: the start is held pending, and RUN is entered on the first gap-ok cycle.
  - stop cancels a pending start.
  - start and stop in the same cycle: stop wins; stay IDLE.
  - manual_trig (with no start): if gap ok, sync=1 on the next cycle and pulse_cnt is unchanged. Otherwise trig_drop=1 on the next cycle and no pulse.
  - manual_trig together with start: start takes priority and the trigger is dropped (trig_drop=1).
- RUN state:
  - The down-counter decrements each cycle. At 0 it emits sync=1 on the next cycle, reloads eff_period-1, and increments pulse_cnt (which wraps modulo 2^CNT_W in continuous mode).
  - Rise-to-rise spacing is exactly eff_period cycles.
  - Finite burst (burst_len≠0): the pulse that makes pulse_cnt == burst_len is the last one. done=1 in the same cycle as that sync, then IDLE with busy=0 on the following cycle.
  - stop=1: IDLE on the next cycle with busy=0 and no done. If stop coincides with a due pulse, stop wins and the pulse is suppressed.
  - start is ignored.
  - manual_trig gives trig_drop=1 on the next cycle.
- sync is never high on two consecutive cycles, and never rises fewer than MIN_GAP cycles after the previous rise. This is a required invariant for verification.
- Asynchronous reset mid-burst forces all reset values immediately; no done is produced.

Test Plan:
- Reset release, then start with period=10, burst_len=3: sync rises at cycles T+1, T+11, T+21. done coincides with the third pulse, busy=0 at T+22, pulse_cnt=3.
- Start with period=2 (MIN_GAP=6), burst_len=4: pulses are spaced exactly 6 cycles apart. pulse_cnt=4, done=1 once.
- Continuous mode: burst_len=0, period=8, run 300 pulses with CNT_W=8. pulse_cnt wraps 255→0, and stop at an arbitrary point gives busy=0 the next cycle, no done, and no further sync.
- stop asserted in the exact cycle the counter hits 0: no sync pulse; IDLE on the next cycle.
- manual_trig at IDLE cycles 0, 3 and 6 (MIN_GAP=6): sync after the first, trig_drop after the second, sync after the third. manual_trig during RUN gives trig_drop only.
- Assert rst_n=0 mid-burst for 1 cycle, then re-start: all outputs are 0 during reset, and the first pulse follows the new start by 1 cycle.

Source files
------------

// File: rtl/sync_pulse_gen_if.sv
// Control/status bundle between a pulse-generator client and sync_pulse_gen.
// Latency: none (wires only).
// Backpressure: none; rejected triggers are reported on trig_drop.
interface sync_pulse_gen_if #(
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 8
);
    logic                start;
    logic                stop;
    logic                manual_trig;
    logic [PERIOD_W-1:0] period;
    logic [CNT_W-1:0]    burst_len;
    logic                sync;
    logic                busy;
    logic                done;
    logic                trig_drop;
    logic [CNT_W-1:0]    pulse_cnt;

    // Client side: issues requests, observes pulses and status.
    modport master (
        output start, stop, manual_trig, period, burst_len,
        input  sync, busy, done, trig_drop, pulse_cnt
    );

    // Generator side.
    modport slave (
        input  start, stop, manual_trig, period, burst_len,
        output sync, busy, done, trig_drop, pulse_cnt
    );
endinterface

// File: rtl/sync_pulse_gen.sv
// Periodic / one-shot single-cycle sync pulse generator with a minimum pulse spacing.
// Latency: accepted start or manual_trig produces sync one clka cycle later; all outputs registered.
// Backpressure: none; a start inside the gap window is held pending, a blocked manual_trig raises trig_drop.
module sync_pulse_gen #(
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 8,
    parameter int MIN_GAP  = 6
) (
    input  logic            clka,
    input  logic            rst_n,
    sync_pulse_gen_if.slave bus
);

    localparam int                  GAP_W   = $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0]    GAP_MAX = GAP_W'(MIN_GAP);
    localparam logic [PERIOD_W-1:0] MIN_PER = PERIOD_W'(MIN_GAP);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [GAP_W-1:0]    r_gap,    w_gap_nxt;
    logic [PERIOD_W-1:0] r_down,   w_down_nxt;
    logic [PERIOD_W-1:0] r_period, w_period_nxt;
    logic [CNT_W-1:0]    r_burst,  w_burst_nxt;
    logic                r_pend,   w_pend_nxt;
    logic                r_sync,   w_sync_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_done,   w_done_nxt;
    logic                r_drop,   w_drop_nxt;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;

    logic [GAP_W-1:0]    w_gap_inc;
    logic                w_gap_ok;
    logic [PERIOD_W-1:0] w_in_eff;
    logic [PERIOD_W-1:0] w_per_sel;
    logic [CNT_W-1:0]    w_bl_sel;
    logic [CNT_W-1:0]    w_cnt_inc;

    // A pulse decided now lands next cycle, so judge the gap it would see then.
    assign w_gap_inc = (r_gap == GAP_MAX) ? GAP_MAX : r_gap + GAP_W'(1);
    assign w_gap_ok  = (w_gap_inc == GAP_MAX);
    assign w_in_eff  = (bus.period < MIN_PER) ? MIN_PER : bus.period;
    // A fresh start uses the live inputs; a pending start uses what was latched.
    assign w_per_sel = bus.start ? w_in_eff : r_period;
    assign w_bl_sel  = bus.start ? bus.burst_len : r_burst;
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Next-state and registered-output decisions for IDLE/RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_down_nxt   = r_down;
        w_period_nxt = r_period;
        w_burst_nxt  = r_burst;
        w_pend_nxt   = r_pend;
        w_sync_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_drop_nxt   = 1'b0;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.stop) begin
                    w_pend_nxt = 1'b0;
                end else if (bus.start || r_pend) begin
                    if (bus.start) begin
                        w_period_nxt = w_in_eff;
                        w_burst_nxt  = bus.burst_len;
                    end
                    if (w_gap_ok) begin
                        w_state_nxt = RUN;
                        w_pend_nxt  = 1'b0;
                        w_sync_nxt  = 1'b1;
                        w_cnt_nxt   = CNT_W'(1);
                        w_down_nxt  = w_per_sel - PERIOD_W'(1);
                        w_done_nxt  = (w_bl_sel == CNT_W'(1));
                    end else begin
                        w_pend_nxt = 1'b1;
                    end
                end
                // A start (live or pending) outranks a manual trigger.
                if (bus.manual_trig) begin
                    if (bus.start || r_pend || !w_gap_ok) begin
                        w_drop_nxt = 1'b1;
                    end else begin
                        w_sync_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                w_drop_nxt = bus.manual_trig;
                if (r_done || bus.stop) begin
                    // Leave after the final pulse cycle, or abort (stop beats a due pulse).
                    w_state_nxt = IDLE;
                end else if (r_down == '0) begin
                    w_sync_nxt = 1'b1;
                    w_down_nxt = r_period - PERIOD_W'(1);
                    w_cnt_nxt  = w_cnt_inc;
                    w_done_nxt = (r_burst != '0) && (w_cnt_inc == r_burst);
                end else begin
                    w_down_nxt = r_down - PERIOD_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt == RUN);
        w_gap_nxt  = w_sync_nxt ? '0 : w_gap_inc;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_gap    <= GAP_MAX;
            r_down   <= '0;
            r_period <= '0;
            r_burst  <= '0;
            r_pend   <= 1'b0;
            r_sync   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gap    <= w_gap_nxt;
            r_down   <= w_down_nxt;
            r_period <= w_period_nxt;
            r_burst  <= w_burst_nxt;
            r_pend   <= w_pend_nxt;
            r_sync   <= w_sync_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_drop   <= w_drop_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.sync      = r_sync;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.trig_drop = r_drop;
    assign bus.pulse_cnt = r_cnt;

endmodule

// File: tb/tb_sync_pulse_gen.sv
// Scoreboard bench for sync_pulse_gen: expected pulse events queued by stimulus, popped by a monitor.
// Latency: events are timestamped in clka cycles.
// Backpressure: none.
module tb_sync_pulse_gen;

    localparam int MIN_GAP = 6;

    logic clka = 1'b0;
    logic rst_n = 1'b0;
    always #5 clka = ~clka;

    sync_pulse_gen_if #(.PERIOD_W(8), .CNT_W(8)) bus ();

    sync_pulse_gen #(.PERIOD_W(8), .CNT_W(8), .MIN_GAP(MIN_GAP)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       s;
        logic       d;
        logic       dr;
        logic [7:0] n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_sync = -1000;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic s, input logic d, input logic dr, input int n);
        exp_t e;
        e.c = c; e.s = s; e.d = d; e.dr = dr; e.n = 8'(n);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_start(input int per, input int bl);
        bus.start     = 1'b1;
        bus.period    = 8'(per);
        bus.burst_len = 8'(bl);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_trig();
        bus.manual_trig = 1'b1;
        tick();
        bus.manual_trig = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync"}, int'(bus.sync), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_drop"}, int'(bus.trig_drop), 0);
        check({tag, "_cnt"},  int'(bus.pulse_cnt), 0);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clka) begin
        exp_t e;
        if (rst_n && (bus.sync || bus.done || bus.trig_drop)) begin
            if (bus.sync) begin
                check("sync_spacing_ok", int'((cyc - last_sync) >= MIN_GAP), 1);
                last_sync = cyc;
            end
            if (sb.size() == 0) begin
                check("unexpected_event_cycle", cyc, -1);
            end else begin
                e = sb.pop_front();
                check("evt_cycle", cyc, e.c);
                check("evt_sync", int'(bus.sync), int'(e.s));
                check("evt_done", int'(bus.done), int'(e.d));
                check("evt_drop", int'(bus.trig_drop), int'(e.dr));
                check("evt_cnt", int'(bus.pulse_cnt), int'(e.n));
            end
        end
    end

    int t;

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.manual_trig = 1'b0;
        bus.period = '0;  bus.burst_len = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Finite burst, period 10, three pulses.
        t = cyc;
        push(t + 1, 1, 0, 0, 1);
        push(t + 11, 1, 0, 0, 2);
        push(t + 21, 1, 1, 0, 3);
        do_start(10, 3);
        wait_cyc(t + 21);
        check("s1_busy_last", int'(bus.busy), 1);
        wait_cyc(t + 22);
        check("s1_busy_after", int'(bus.busy), 0);
        check("s1_cnt", int'(bus.pulse_cnt), 3);

        // Period below MIN_GAP clamps to MIN_GAP.
        wait_cyc(cyc + 10);
        t = cyc;
        push(t + 1, 1, 0, 0, 1);
        push(t + 7, 1, 0, 0, 2);
        push(t + 13, 1, 0, 0, 3);
        push(t + 19, 1, 1, 0, 4);
        do_start(2, 4);
        wait_cyc(t + 20);
        check("s2_busy_after", int'(bus.busy), 0);
        check("s2_cnt", int'(bus.pulse_cnt), 4);

        // Continuous mode, 300 pulses with pulse_cnt wrapping, then stop.
        wait_cyc(cyc + 10);
        t = cyc;
        for (int k = 0; k < 300; k++) push(t + 1 + 8 * k, 1, 0, 0, (k + 1) % 256);
        do_start(8, 0);
        wait_cyc(t + 2396);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("s3_busy_after_stop", int'(bus.busy), 0);
        wait_cyc(t + 2420);
        check("s3_cnt", int'(bus.pulse_cnt), 44);

        // Stop in the exact cycle the down-counter reaches zero.
        wait_cyc(cyc + 10);
        t = cyc;
        push(t + 1, 1, 0, 0, 1);
        push(t + 11, 1, 0, 0, 2);
        do_start(10, 5);
        wait_cyc(t + 20);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("s4_busy_after_stop", int'(bus.busy), 0);
        check("s4_no_sync", int'(bus.sync), 0);
        wait_cyc(t + 30);
        check("s4_cnt", int'(bus.pulse_cnt), 2);

        // Manual triggers at IDLE cycles 0, 3, 6.
        wait_cyc(cyc + 10);
        t = cyc;
        push(t + 1, 1, 0, 0, 2);
        push(t + 4, 0, 0, 1, 2);
        push(t + 7, 1, 0, 0, 2);
        do_trig();
        wait_cyc(t + 3);
        do_trig();
        wait_cyc(t + 6);
        do_trig();
        check("s5_busy_idle", int'(bus.busy), 0);

        // Manual trigger during RUN is dropped.
        wait_cyc(t + 20);
        t = cyc;
        push(t + 1, 1, 0, 0, 1);
        push(t + 5, 0, 0, 1, 1);
        push(t + 11, 1, 1, 0, 2);
        do_start(10, 2);
        wait_cyc(t + 4);
        do_trig();
        wait_cyc(t + 12);
        check("s6_busy_after", int'(bus.busy), 0);

        // start + manual_trig together: start wins; burst of one gives done at once.
        wait_cyc(t + 25);
        t = cyc;
        push(t + 1, 1, 1, 1, 1);
        bus.manual_trig = 1'b1;
        do_start(10, 1);
        bus.manual_trig = 1'b0;

        // start inside the gap window is held pending until the gap opens.
        wait_cyc(t + 3);
        push(t + 7, 1, 1, 0, 1);
        do_start(10, 1);
        wait_cyc(t + 5);
        check("s7_pending_not_busy", int'(bus.busy), 0);
        wait_cyc(t + 7);
        check("s7_busy_on_pulse", int'(bus.busy), 1);
        wait_cyc(t + 8);
        check("s7_busy_after", int'(bus.busy), 0);

        // Reset mid-burst, then restart.
        wait_cyc(t + 30);
        t = cyc;
        push(t + 1, 1, 0, 0, 1);
        do_start(10, 3);
        wait_cyc(t + 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        wait_cyc(t + 8);
        push(t + 9, 1, 1, 0, 1);
        do_start(10, 1);
        wait_cyc(t + 12);
        check("s8_busy_after", int'(bus.busy), 0);

        wait_cyc(cyc + 20);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
